// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state encoding.
// Used by uart_rx and the FTDI TX block; no ports.
package uart_pkg;
    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 2500;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: N-flop synchroniser for an asynchronous serial line, resets to idle-high.
// Ports: clk_i clock, rst_n async active-low reset, d_i async input, q_o synchronised output.
module uart_rx_sync #(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [N-1:0] ff_q;
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) ff_q <= '1;
        else        ff_q <= {ff_q[N-2:0], d_i};
    end
    assign q_o = ff_q[N-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined) with a one-entry valid/ready holding register.
// Ports: clk_25mhz clock, rst_n async active-low reset, ftdi_rxd async serial input,
//        rx_data/rx_valid/rx_ready byte handshake, frame_err/overrun one-cycle error pulses,
//        parity_err one-cycle pulse (only with UART_RX_PARITY_EN).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk_25mhz,
    input  logic                 rst_n,
    input  logic                 ftdi_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic                 rxd_s, rxd_prev_q;
    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q;
    logic                 valid_q, frame_err_q, overrun_q;
    logic                 stop_smp, par_ok, good;

    uart_rx_sync #(.N(SYNC_STAGES)) u_sync (
        .clk_i (clk_25mhz),
        .rst_n (rst_n),
        .d_i   (ftdi_rxd),
        .q_o   (rxd_s)
    );

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d, parity_err_q;
    // Even parity: the received parity bit must equal the XOR of the data bits.
    assign par_ok     = (par_q == ^shift_q);
    assign parity_err = parity_err_q;
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        shift_d  = shift_q;
        stop_smp = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rxd_prev_q && !rxd_s) state_d = START;
            end
            START: if (cnt_q == HALF_LAST) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rxd_s ? IDLE : DATA;
            end
            DATA: if (cnt_q == LAST) begin
                cnt_d          = '0;
                shift_d[idx_q] = rxd_s;
                idx_d          = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (idx_q == 3'(DATA_BITS - 1)) state_d = PARITY;
`else
                if (idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (cnt_q == LAST) begin
                cnt_d   = '0;
                par_d   = rxd_s;
                state_d = STOP;
            end
`endif
            STOP: if (cnt_q == LAST) begin
                cnt_d    = '0;
                stop_smp = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign good = stop_smp && rxd_s && par_ok;

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rxd_prev_q  <= 1'b1;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rxd_prev_q  <= rxd_s;
            frame_err_q <= stop_smp && !rxd_s;
            // A good byte arriving while the held byte is not being drained is dropped.
            overrun_q   <= good && valid_q && !rx_ready;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= stop_smp && !par_ok;
`endif
            if (good && !(valid_q && !rx_ready)) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with directed frames and a randomised frame-level model.
module tb_uart_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk_25mhz (clk),
        .rst_n     (rst_n),
        .ftdi_rxd  (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun)
    );

    int checks = 0, failures = 0;
    int ferr_n = 0, ovr_n = 0, perr_n = 0;
    logic [7:0] acc[$];

    // Observed events: accepted bytes and error-pulse cycles.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) acc.push_back(rx_data);
            if (frame_err) ferr_n++;
            if (overrun) ovr_n++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) perr_n++;
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] acc_at(input int i);
        return (acc.size() > i) ? {24'h0, acc[i]} : 32'hdead;
    endfunction

    task automatic clear();
        ferr_n = 0;
        ovr_n  = 0;
        perr_n = 0;
        acc.delete();
    endtask

    task automatic hold(input logic v, input int n);
        rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_v, input logic pflip, input int gap);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
`ifdef UART_RX_PARITY_EN
        hold((^b) ^ pflip, CPB);
`else
        if (pflip) hold(1'b1, 0);
`endif
        hold(stop_v, CPB);
        hold(1'b1, gap);
    endtask

    logic       mv, rdy, sbad, pbad, good, eo;
    logic [7:0] mh, b;
    logic [7:0] exp_q[$];

    initial begin
        hold(1'b1, 3);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        hold(1'b1, 4);

        rx_ready = 1'b1;
        clear();
        send(8'h41, 1'b1, 1'b0, 4);
        check("t41_cnt", acc.size(), 1);
        check("t41_data", acc_at(0), 32'h41);
        check("t41_ferr", ferr_n, 0);
        check("t41_valid_low", rx_valid, 0);

        rx_ready = 1'b0;
        clear();
        send(8'hA5, 1'b1, 1'b0, 0);
        send(8'h3C, 1'b1, 1'b0, 4);
        check("ovr_cnt", ovr_n, 1);
        check("ovr_valid", rx_valid, 1);
        check("ovr_held", rx_data, 32'hA5);
        check("ovr_noacc", acc.size(), 0);
        rx_ready = 1'b1;
        hold(1'b1, 2);
        check("ovr_drain_cnt", acc.size(), 1);
        check("ovr_drain_data", acc_at(0), 32'hA5);
        check("ovr_drain_valid", rx_valid, 0);

        clear();
        send(8'h55, 1'b0, 1'b0, 8);
        check("fe_cnt", ferr_n, 1);
        check("fe_noacc", acc.size(), 0);
        check("fe_valid", rx_valid, 0);
        clear();
        send(8'h12, 1'b1, 1'b0, 4);
        check("fe_next_cnt", acc.size(), 1);
        check("fe_next_data", acc_at(0), 32'h12);
        check("fe_next_ferr", ferr_n, 0);

        clear();
        hold(1'b0, 4);
        hold(1'b1, 40);
        check("gl_noacc", acc.size(), 0);
        check("gl_ferr", ferr_n, 0);
        check("gl_valid", rx_valid, 0);

        clear();
        hold(1'b0, CPB);
        hold(1'b1, 4 * CPB + CPB / 2);
        rst_n = 1'b0;
        hold(1'b1, 3);
        check("mr_valid", rx_valid, 0);
        rst_n = 1'b1;
        hold(1'b1, 4);
        send(8'h0F, 1'b1, 1'b0, 4);
        check("mr_cnt", acc.size(), 1);
        check("mr_data", acc_at(0), 32'h0F);
        check("mr_ferr", ferr_n, 0);

`ifdef UART_RX_PARITY_EN
        clear();
        send(8'h07, 1'b1, 1'b1, 4);
        check("par_bad_perr", perr_n, 1);
        check("par_bad_noacc", acc.size(), 0);
        clear();
        send(8'h07, 1'b1, 1'b0, 4);
        check("par_ok_cnt", acc.size(), 1);
        check("par_ok_data", acc_at(0), 32'h07);
        check("par_ok_perr", perr_n, 0);
`endif

        // Frame-level model: one holding slot, drained whenever ready is high.
        mv = 1'b0;
        mh = 8'h00;
        for (int f = 0; f < 24; f++) begin
            rdy  = ($urandom_range(0, 2) != 0);
            b    = 8'($urandom);
            sbad = ($urandom_range(0, 4) == 0);
`ifdef UART_RX_PARITY_EN
            pbad = ($urandom_range(0, 4) == 0);
`else
            pbad = 1'b0;
`endif
            rx_ready = rdy;
            clear();
            exp_q.delete();
            if (rdy && mv) begin
                exp_q.push_back(mh);
                mv = 1'b0;
            end
            send(b, !sbad, pbad, 4 + $urandom_range(0, 8));
            good = !sbad && !pbad;
            eo   = good && mv && !rdy;
            if (good && !eo) begin
                if (rdy) exp_q.push_back(b);
                else begin
                    mv = 1'b1;
                    mh = b;
                end
            end
            check("rnd_ferr", ferr_n, {31'h0, sbad});
            check("rnd_ovr", ovr_n, {31'h0, eo});
`ifdef UART_RX_PARITY_EN
            check("rnd_perr", perr_n, {31'h0, pbad});
`endif
            check("rnd_cnt", acc.size(), exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) check("rnd_data", acc_at(i), {24'h0, exp_q[i]});
            check("rnd_valid", rx_valid, {31'h0, mv});
            if (mv) check("rnd_held", rx_data, {24'h0, mh});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
